// File: rtl/freq_word_calc_if.sv
// Frequency request in, tuning word and status out.
// The master drives f; the slave returns M and its flags.
interface freq_word_calc_if #(
  parameter int F_W = 18,
  parameter int N   = 30
);
  logic [F_W-1:0] f;
  logic [N-1:0]   M;
  logic           M_valid;
  logic           M_upd;
  logic           busy;

  modport master (
    output f,
    input  M, M_valid, M_upd, busy
  );

  modport slave (
    input  f,
    output M, M_valid, M_upd, busy
  );
endinterface

// File: rtl/freq_word_calc.sv
// Hz request -> DDS tuning word via an 18-cycle shift-add multiply.
// Optional input debounce: define FREQ_DEBOUNCE_EN.
module freq_word_calc #(
  parameter int N    = 30,
  parameter int F_W  = 18,
  parameter int K    = 1407375,
  parameter int K_W  = 21,
  parameter int FRAC = 16
`ifdef FREQ_DEBOUNCE_EN
  ,
  parameter int STABLE_CYC = 50000
`endif
) (
  input  logic             CLK_fc,
  input  logic             RST,
  freq_word_calc_if.slave  bus
);

  localparam int ACC_W = F_W + K_W;
  localparam int CNT_W = $clog2(F_W);

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [ACC_W:0]   rnd_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam rnd_t HALF = rnd_t'(1) << (FRAC - 1);
  localparam acc_t KX   = acc_t'(K);
  localparam cnt_t LAST = cnt_t'(F_W - 1);

`ifdef FREQ_DEBOUNCE_EN
  localparam int W_W = $clog2(STABLE_CYC + 1);
  typedef logic [W_W-1:0] wcnt_t;
  localparam wcnt_t W_END = wcnt_t'(STABLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t         state;
  logic [F_W-1:0] f_s1;
  logic [F_W-1:0] f_s2;
  logic [F_W-1:0] f_cap;
  acc_t           acc;
  cnt_t           cnt;
  logic           pend;
  logic [N-1:0]   m_q;
  logic           valid_q;
  logic           upd_q;
  acc_t           kterm;
  rnd_t           rnd;

`ifdef FREQ_DEBOUNCE_EN
  logic [F_W-1:0] f_prev;
  wcnt_t          wcnt;
`endif

  assign kterm = KX << cnt;
  assign rnd   = rnd_t'(acc) + HALF;

  assign bus.M       = m_q;
  assign bus.M_valid = valid_q;
  assign bus.M_upd   = upd_q;
  assign bus.busy    = (state != IDLE);

  always_ff @(posedge CLK_fc) begin
    if (RST) begin
      state   <= IDLE;
      f_s1    <= '0;
      f_s2    <= '0;
      f_cap   <= '0;
      acc     <= '0;
      cnt     <= '0;
      pend    <= 1'b1;
      m_q     <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
`ifdef FREQ_DEBOUNCE_EN
      f_prev  <= '0;
      wcnt    <= '0;
`endif
    end else begin
      f_s1  <= bus.f;
      f_s2  <= f_s1;
      upd_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend) begin
            f_cap <= f_s2;
            acc   <= '0;
            cnt   <= '0;
            pend  <= 1'b0;
            state <= CALC;
          end else if (f_s2 != f_cap) begin
`ifdef FREQ_DEBOUNCE_EN
            f_prev <= f_s2;
            wcnt   <= '0;
            state  <= WAIT;
`else
            f_cap <= f_s2;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
`endif
          end
        end
`ifdef FREQ_DEBOUNCE_EN
        WAIT: begin
          f_prev <= f_s2;
          if (f_s2 != f_prev) begin
            wcnt <= '0;
          end else if (wcnt == W_END) begin
            // settled back on the old value: nothing to recompute
            if (f_s2 != f_cap) begin
              f_cap <= f_s2;
              acc   <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              state <= IDLE;
            end
          end else begin
            wcnt <= wcnt + wcnt_t'(1);
          end
        end
`endif
        CALC: begin
          if (f_cap[cnt]) acc <= acc + kterm;
          cnt <= cnt + cnt_t'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          m_q     <= N'(rnd >> FRAC);
          upd_q   <= 1'b1;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_word_calc.sv
// Directed bench for freq_word_calc (default build, no debounce).
// Expected tuning words are hand-computed round(f*2^46/50e6/2^16).
module tb_freq_word_calc;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n;
  int   pulses;

  freq_word_calc_if #(.F_W(18), .N(30)) bus ();

  freq_word_calc dut (
    .CLK_fc (clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int max, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.M_upd && cyc < max);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.f  = '0;
    tick(3);
    check("rst_M", 64'(bus.M), 0);
    check("rst_valid", 64'(bus.M_valid), 0);
    check("rst_upd", 64'(bus.M_upd), 0);
    check("rst_busy", 64'(bus.busy), 0);

    // forced first compute after reset
    rst = 1'b0;
    wait_upd(100, n);
    check("pend_lat", 64'(n), 20);
    check("pend_M", 64'(bus.M), 0);
    check("pend_valid", 64'(bus.M_valid), 1);
    check("pend_busy", 64'(bus.busy), 0);

    bus.f = 18'd10000;
    wait_upd(100, n);
    check("f10k_lat", 64'(n), 22);
    check("f10k_M", 64'(bus.M), 214748);

    bus.f = 18'd0;
    wait_upd(100, n);
    check("f0_lat", 64'(n), 22);
    check("f0_M", 64'(bus.M), 0);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (bus.M_upd) pulses++;
    end
    check("hold_pulses", 64'(pulses), 0);
    check("hold_M", 64'(bus.M), 0);

    // max input, stepwise
    bus.f = 18'd262143;
    tick(2);
    check("max_busy_e2", 64'(bus.busy), 0);
    tick(1);
    check("max_busy_e3", 64'(bus.busy), 1);
    tick(18);
    check("max_busy_e21", 64'(bus.busy), 1);
    check("max_upd_e21", 64'(bus.M_upd), 0);
    tick(1);
    check("max_upd_e22", 64'(bus.M_upd), 1);
    check("max_M", 64'(bus.M), 5629479);
    check("max_busy_e22", 64'(bus.busy), 0);
    tick(1);
    check("max_upd_e23", 64'(bus.M_upd), 0);
    check("max_M_hold", 64'(bus.M), 5629479);

    // change during CALC
    bus.f = 18'd1000;
    tick(5);
    bus.f = 18'd2000;
    wait_upd(100, n);
    check("mid_lat1", 64'(n), 17);
    check("mid_M1", 64'(bus.M), 21475);
    wait_upd(100, n);
    check("mid_gap", 64'(n), 20);
    check("mid_M2", 64'(bus.M), 42950);

    // reset mid-CALC at cnt=9
    bus.f = 18'd5000;
    tick(12);
    check("rc_busy_pre", 64'(bus.busy), 1);
    rst = 1'b1;
    tick(1);
    check("rc_M", 64'(bus.M), 0);
    check("rc_valid", 64'(bus.M_valid), 0);
    check("rc_busy", 64'(bus.busy), 0);
    check("rc_upd", 64'(bus.M_upd), 0);
    rst = 1'b0;
    wait_upd(100, n);
    check("rc_pend_lat", 64'(n), 20);
    check("rc_pend_M", 64'(bus.M), 0);
    wait_upd(100, n);
    check("rc_lat", 64'(n), 20);
    check("rc_M_final", 64'(bus.M), 107374);
    check("rc_valid_final", 64'(bus.M_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
